// File: rtl/jpeg_dct_pkg.sv
// Shared constants, state encoding and pixel packing for the JPEG row DCT/IDCT blocks.
// Q7 cosine constants: Ck = round(128*cos(k*pi/16)).
package jpeg_dct_pkg;

  localparam int IDCT_CW        = 9;
  localparam int IDCT_ACC_W     = 20;
  localparam int IDCT_OUT_SHIFT = 6;

  localparam int C1 = 126;
  localparam int C2 = 118;
  localparam int C3 = 106;
  localparam int C4 = 91;
  localparam int C5 = 71;
  localparam int C6 = 49;
  localparam int C7 = 25;

  typedef enum logic [1:0] {COLLECT, PIPE, HOLD} idct_state_t;

  // Pixel n lives in byte (7-n), so pixel0 is the most significant byte.
  function automatic logic [63:0] pix_place(input logic [63:0] word, input int n,
                                            input logic [7:0] p);
    logic [63:0] w;
    w = word;
    w[(7-n)*8 +: 8] = p;
    return w;
  endfunction

endpackage

// File: rtl/idct_1d_row_dp.sv
// 8-point row IDCT datapath: S1 even products, S2 odd products + butterflies, S3 combine/clamp.
// Latency 3 enabled edges (stg_en[0..2]); no internal backpressure, coefs must stay stable.
// IDCT_ROUND_EN adds half an output LSB before the shift; otherwise the shift truncates.
module idct_1d_row_dp
  import jpeg_dct_pkg::*;
#(
  parameter int CW        = IDCT_CW,
  parameter int ACC_W     = IDCT_ACC_W,
  parameter int OUT_SHIFT = IDCT_OUT_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          stg_en,
  input  logic [7:0][CW-1:0]  coefs,
  output logic [63:0]         pix_out,
  output logic [7:0]          pix_sat
);

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t K1 = acc_t'(C1);
  localparam acc_t K2 = acc_t'(C2);
  localparam acc_t K3 = acc_t'(C3);
  localparam acc_t K4 = acc_t'(C4);
  localparam acc_t K5 = acc_t'(C5);
  localparam acc_t K6 = acc_t'(C6);
  localparam acc_t K7 = acc_t'(C7);
  localparam acc_t PIX_MAX = acc_t'(255);
`ifdef IDCT_ROUND_EN
  localparam acc_t RND = acc_t'(1) <<< (OUT_SHIFT - 1);
`endif

  acc_t x [8];
  acc_t a0, a1, b0, b1;
  acc_t e [4];
  acc_t o [4];
  acc_t sum, p;
  logic [7:0]  px;
  logic [63:0] pix_nxt;
  logic [7:0]  sat_nxt;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      x[k] = acc_t'(signed'(coefs[k]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= '0;
      a1 <= '0;
      b0 <= '0;
      b1 <= '0;
    end else if (stg_en[0]) begin
      a0 <= K4 * (x[0] + x[4]);
      a1 <= K4 * (x[0] - x[4]);
      b0 <= K2 * x[2] + K6 * x[6];
      b1 <= K6 * x[2] - K2 * x[6];
    end
  end

  // Odd part signs come from folding k(2n+1)*pi/16 into the first quadrant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        e[i] <= '0;
        o[i] <= '0;
      end
    end else if (stg_en[1]) begin
      e[0] <= a0 + b0;
      e[1] <= a1 + b1;
      e[2] <= a1 - b1;
      e[3] <= a0 - b0;
      o[0] <= K1 * x[1] + K3 * x[3] + K5 * x[5] + K7 * x[7];
      o[1] <= K3 * x[1] - K7 * x[3] - K1 * x[5] - K5 * x[7];
      o[2] <= K5 * x[1] - K1 * x[3] + K7 * x[5] + K3 * x[7];
      o[3] <= K7 * x[1] - K5 * x[3] + K3 * x[5] - K1 * x[7];
    end
  end

  always_comb begin
    pix_nxt = '0;
    sat_nxt = '0;
    sum     = '0;
    p       = '0;
    px      = '0;
    for (int n = 0; n < 8; n++) begin
      if (n < 4) sum = e[n] + o[n];
      else       sum = e[7-n] - o[7-n];
`ifdef IDCT_ROUND_EN
      sum = sum + RND;
`endif
      p = sum >>> OUT_SHIFT;
      if (p[ACC_W-1]) begin
        px = 8'h00;
        sat_nxt[7-n] = 1'b1;
      end else if (p > PIX_MAX) begin
        px = 8'hFF;
        sat_nxt[7-n] = 1'b1;
      end else begin
        px = p[7:0];
      end
      pix_nxt = pix_place(pix_nxt, n, px);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out <= '0;
      pix_sat <= '0;
    end else if (stg_en[2]) begin
      pix_out <= pix_nxt;
      pix_sat <= sat_nxt;
    end
  end

endmodule

// File: rtl/idct_1d_row.sv
// Inverse 8-point row DCT: collects X0..X7 serially, emits 8 clamped pixels as one 64-bit word.
// Latency: out_valid rises 3 cycles after the X7 transfer; no coefs accepted until the row is taken.
// Output held under out_ready=0; optional rounding via IDCT_ROUND_EN (handled in the datapath).
module idct_1d_row
  import jpeg_dct_pkg::*;
#(
  parameter int CW        = IDCT_CW,
  parameter int ACC_W     = IDCT_ACC_W,
  parameter int OUT_SHIFT = IDCT_OUT_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] coef_in,
  input  logic          coef_first,
  input  logic          coef_valid,
  output logic          coef_ready,
  output logic [63:0]   pix_out,
  output logic [7:0]    pix_sat,
  output logic          out_valid,
  input  logic          out_ready
);

  idct_state_t         state, state_nxt;
  logic [2:0]          idx, idx_nxt;
  logic [1:0]          stg, stg_nxt;
  logic [2:0]          stg_en;
  logic                out_valid_nxt;
  logic                coef_xfer;
  logic [2:0]          wr_idx;
  logic [7:0][CW-1:0]  coefs;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    stg_nxt       = stg;
    stg_en        = '0;
    out_valid_nxt = out_valid;
    coef_ready    = 1'b0;
    coef_xfer     = 1'b0;
    case (state)
      COLLECT: begin
        coef_ready = 1'b1;
        coef_xfer  = coef_valid;
        if (coef_valid) begin
          if (coef_first) begin
            idx_nxt = 3'd1;
          end else if (idx == 3'd7) begin
            idx_nxt   = 3'd0;
            stg_nxt   = 2'd0;
            state_nxt = PIPE;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      PIPE: begin
        stg_en  = 3'b001 << stg;
        stg_nxt = stg + 2'd1;
        if (stg == 2'd2) begin
          out_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          idx_nxt       = 3'd0;
          state_nxt     = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // A row-start marker always lands in slot 0, dropping any partial row.
  assign wr_idx = coef_first ? 3'd0 : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      idx       <= '0;
      stg       <= '0;
      out_valid <= 1'b0;
      coefs     <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      stg       <= stg_nxt;
      out_valid <= out_valid_nxt;
      if (coef_xfer) coefs[wr_idx] <= coef_in;
    end
  end

  idct_1d_row_dp #(
    .CW        (CW),
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .stg_en  (stg_en),
    .coefs   (coefs),
    .pix_out (pix_out),
    .pix_sat (pix_sat)
  );

endmodule

// File: tb/tb_idct_1d_row.sv
// Directed bench for idct_1d_row: reset, DC rows, clamping, X7 use, backpressure, resync, round-trip.
// Expected words are hand-derived for both the IDCT_ROUND_EN and truncating builds.
module tb_idct_1d_row;

  logic        clk;
  logic        rst_n;
  logic [8:0]  coef_in;
  logic        coef_first;
  logic        coef_valid;
  logic        coef_ready;
  logic [63:0] pix_out;
  logic [7:0]  pix_sat;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;
  int row [8];
  int cyc;

`ifdef IDCT_ROUND_EN
  localparam logic [63:0] EXP_DC90 = 64'h8080808080808080;
  localparam logic [63:0] EXP_RAMP = 64'h0020405E82A1C1E1;
  localparam logic [63:0] EXP_X7   = 64'h8475916C946F8B7C;
`else
  localparam logic [63:0] EXP_DC90 = 64'h7F7F7F7F7F7F7F7F;
  localparam logic [63:0] EXP_RAMP = 64'h00203F5E82A0C0E1;
  localparam logic [63:0] EXP_X7   = 64'h8374906C936F8B7C;
`endif

  idct_1d_row dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_in    (coef_in),
    .coef_first (coef_first),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .pix_out    (pix_out),
    .pix_sat    (pix_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_coef(input int v, input logic first);
    int n;
    n = 0;
    coef_in    = v[8:0];
    coef_first = first;
    coef_valid = 1'b1;
    @(negedge clk);
    while (!coef_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!coef_ready) chk("coef_ready_timeout", {63'd0, coef_ready}, 64'd1);
    @(posedge clk);
    #1;
    coef_valid = 1'b0;
    coef_first = 1'b0;
  endtask

  task automatic send_row(input logic use_first);
    for (int k = 0; k < 8; k++) send_coef(row[k], use_first && (k == 0));
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!out_valid) chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic run_row(input string tag, input logic use_first,
                         input logic [63:0] epix, input logic [7:0] esat);
    out_ready = 1'b1;
    send_row(use_first);
    wait_out(cyc);
    chk({tag, "_pix"}, pix_out, epix);
    chk({tag, "_sat"}, {56'd0, pix_sat}, {56'd0, esat});
    @(posedge clk);
    #1;
    chk({tag, "_taken"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Each pixel within +/-2 of base + step*n.
  task automatic near_check(input string tag, input logic [63:0] word, input int base,
                            input int step);
    int d;
    for (int n = 0; n < 8; n++) begin
      d = int'(word[63-8*n -: 8]) - (base + step * n);
      chk(tag, {63'd0, (d <= 2 && d >= -2)}, 64'd1);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    coef_in    = '0;
    coef_first = 1'b0;
    coef_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_coef_ready", {63'd0, coef_ready}, 64'd1);
    chk("rst_pix_out", pix_out, 64'd0);
    chk("rst_pix_sat", {56'd0, pix_sat}, 64'd0);
    @(posedge clk);
    #1;

    // DC row with explicit latency and handshake checks.
    row = '{90, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    send_row(1'b1);
    wait_out(cyc);
    chk("dc90_latency", 64'(cyc), 64'd3);
    chk("dc90_pix", pix_out, EXP_DC90);
    chk("dc90_sat", {56'd0, pix_sat}, 64'd0);
    chk("dc90_hold_ready", {63'd0, coef_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("dc90_exit_valid", {63'd0, out_valid}, 64'd0);
    chk("dc90_exit_ready", {63'd0, coef_ready}, 64'd1);

    row = '{255, 0, 0, 0, 0, 0, 0, 0};
    run_row("clamp_hi", 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    row = '{-10, 0, 0, 0, 0, 0, 0, 0};
    run_row("clamp_lo", 1'b0, 64'h0, 8'hFF);

    row = '{90, 0, 0, 0, 0, 0, 0, 10};
    run_row("x7_used", 1'b1, EXP_X7, 8'h00);

    // Forward-DCT coefficients (orthonormal/4, rounded) of ramp 0,32,..,224 and of flat 200.
    row = '{79, -52, 0, -5, 0, -2, 0, 0};
    run_row("ramp", 1'b1, EXP_RAMP, 8'h80);
    near_check("ramp_near", pix_out, 0, 32);
    row = '{141, 0, 0, 0, 0, 0, 0, 0};
    run_row("flat200", 1'b1, 64'hC8C8C8C8C8C8C8C8, 8'h00);
    near_check("flat200_near", pix_out, 200, 0);

    // Backpressure: output frozen, input blocked.
    out_ready = 1'b0;
    row = '{90, 0, 0, 0, 0, 0, 0, 0};
    send_row(1'b1);
    wait_out(cyc);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_pix", pix_out, EXP_DC90);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_ready", {63'd0, coef_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_exit_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_exit_ready", {63'd0, coef_ready}, 64'd1);

    // Resync: five stray coefficients, then a marked row.
    send_coef(10, 1'b1);
    send_coef(20, 1'b0);
    send_coef(30, 1'b0);
    send_coef(40, 1'b0);
    send_coef(50, 1'b0);
    chk("resync_partial_valid", {63'd0, out_valid}, 64'd0);
    chk("resync_partial_ready", {63'd0, coef_ready}, 64'd1);
    row = '{90, 0, 0, 0, 0, 0, 0, 0};
    run_row("resync", 1'b1, EXP_DC90, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("resync_single_row", {63'd0, out_valid}, 64'd0);

    // Reset mid-row drops the partial row and clears the output word.
    send_coef(100, 1'b1);
    send_coef(100, 1'b0);
    send_coef(100, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", {63'd0, coef_ready}, 64'd1);
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_pix", pix_out, 64'd0);
    @(posedge clk);
    #1;
    row = '{-10, 0, 0, 0, 0, 0, 0, 0};
    run_row("midrst_row", 1'b0, 64'h0, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
